// File: rtl/eig_seq_ctrl_if.sv
// Handshake/bus bundle between the eigen-solver sequencer, eig_core and the output loader.
// master: the side driving start/core/loader status; slave: the sequencer itself.
interface eig_seq_ctrl_if;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned MODE_W = 3;

   logic              calc_start;
   logic              core_busy;
   logic [WORD_W-1:0] core_kappa;
   logic [WORD_W-1:0] core_inv_kappa;
   logic [MODE_W-1:0] core_regime;
   logic              ol_busy;

   logic              ol_start;
   logic [MODE_W-1:0] ol_mode;
   logic [WORD_W-1:0] ol_word_a;
   logic [WORD_W-1:0] ol_word_b;
   logic              res_valid;
   logic              seq_busy;
   logic              err_overrun;
   logic              err_timeout;

   modport master (
      output calc_start, core_busy, core_kappa, core_inv_kappa, core_regime, ol_busy,
      input  ol_start, ol_mode, ol_word_a, ol_word_b, res_valid, seq_busy,
             err_overrun, err_timeout
   );

   modport slave (
      input  calc_start, core_busy, core_kappa, core_inv_kappa, core_regime, ol_busy,
      output ol_start, ol_mode, ol_word_a, ol_word_b, res_valid, seq_busy,
             err_overrun, err_timeout
   );
endinterface

// File: rtl/eig_seq_ctrl.sv
// Sequencer: start -> wait for eig_core -> capture result -> launch output loader.
// Optional wait-state timeout with ABORT is enabled by defining EIG_SEQ_TIMEOUT_EN.
module eig_seq_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input logic            clk_i,
   input logic            rst_i,
   eig_seq_ctrl_if.slave  seq_if
);
   localparam int unsigned WORD_W = 32;
   localparam int unsigned MODE_W = 3;
   localparam int unsigned CNT_W  = 16;

   if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout_cyc
      $error("eig_seq_ctrl: TIMEOUT_CYC must be within 2..65535");
   end

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARM     = 3'd1,
      S_RUN     = 3'd2,
      S_LAUNCH  = 3'd3,
      S_OL_WAIT = 3'd4,
      S_OL_DONE = 3'd5,
      S_ABORT   = 3'd6
   } state_e;

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   word_a_q, word_a_d;
   logic [WORD_W-1:0]   word_b_q, word_b_d;
   logic [MODE_W-1:0]   mode_q, mode_d;
   logic                ol_start_q, ol_start_d;
   logic                res_valid_q, res_valid_d;
   logic                seq_busy_q, seq_busy_d;
   logic                err_overrun_q, err_overrun_d;
   logic                timeout_hit_c;

`ifdef EIG_SEQ_TIMEOUT_EN
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_timeout_q, err_timeout_d;
   logic                cnt_run_c;

   // Timeout fires when this cycle would be the TIMEOUT_CYC-th spent in the wait state
   always_comb begin
      cnt_run_c     = (state_q == S_ARM) || (state_q == S_RUN) ||
                      (state_q == S_OL_WAIT) || (state_q == S_OL_DONE);
      timeout_hit_c = cnt_run_c &&
                      ((17'(cnt_q) + 17'd1) >= 17'(TIMEOUT_CYC));
   end

   always_comb begin
      cnt_d         = cnt_q;
      err_timeout_d = err_timeout_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_run_c) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (state_d == S_ABORT) begin
         err_timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q         <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign seq_if.err_timeout = err_timeout_q;
`else
   assign timeout_hit_c      = 1'b0;
   assign seq_if.err_timeout = 1'b0;
`endif

   // Next-state and registered-output decode
   always_comb begin
      state_d       = state_q;
      word_a_d      = word_a_q;
      word_b_d      = word_b_q;
      mode_d        = mode_q;
      ol_start_d    = 1'b0;
      res_valid_d   = 1'b0;
      err_overrun_d = err_overrun_q;

      // A start while busy (including the cycle that returns to IDLE) is dropped
      if (seq_if.calc_start && seq_busy_q) begin
         err_overrun_d = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (seq_if.calc_start) begin
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            if (seq_if.core_busy) begin
               state_d = S_RUN;
            end else if (timeout_hit_c) begin
               state_d = S_ABORT;
            end
         end
         S_RUN: begin
            if (!seq_if.core_busy) begin
               word_a_d    = seq_if.core_kappa;
               word_b_d    = seq_if.core_inv_kappa;
               mode_d      = seq_if.core_regime;
               res_valid_d = 1'b1;
               state_d     = S_LAUNCH;
            end else if (timeout_hit_c) begin
               state_d = S_ABORT;
            end
         end
         S_LAUNCH: begin
            if (!seq_if.ol_busy) begin
               ol_start_d = 1'b1;
               state_d    = S_OL_WAIT;
            end
         end
         S_OL_WAIT: begin
            if (seq_if.ol_busy) begin
               state_d = S_OL_DONE;
            end else if (timeout_hit_c) begin
               state_d = S_ABORT;
            end
         end
         S_OL_DONE: begin
            if (!seq_if.ol_busy) begin
               state_d = S_IDLE;
            end else if (timeout_hit_c) begin
               state_d = S_ABORT;
            end
         end
         S_ABORT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      seq_busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         word_a_q      <= '0;
         word_b_q      <= '0;
         mode_q        <= '0;
         ol_start_q    <= 1'b0;
         res_valid_q   <= 1'b0;
         seq_busy_q    <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         word_a_q      <= word_a_d;
         word_b_q      <= word_b_d;
         mode_q        <= mode_d;
         ol_start_q    <= ol_start_d;
         res_valid_q   <= res_valid_d;
         seq_busy_q    <= seq_busy_d;
         err_overrun_q <= err_overrun_d;
      end
   end

   assign seq_if.ol_start    = ol_start_q;
   assign seq_if.ol_mode     = mode_q;
   assign seq_if.ol_word_a   = word_a_q;
   assign seq_if.ol_word_b   = word_b_q;
   assign seq_if.res_valid   = res_valid_q;
   assign seq_if.seq_busy    = seq_busy_q;
   assign seq_if.err_overrun = err_overrun_q;
endmodule

// File: tb/tb_eig_seq_ctrl.sv
// Self-checking bench for eig_seq_ctrl: transaction-level timing model with randomized peers.
module tb_eig_seq_ctrl;
   localparam int unsigned TO_CYC = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Expected architectural values tracked by the bench
   logic [31:0] m_word_a, m_word_b;
   logic [2:0]  m_mode;
   logic        m_ovr, m_tmo;

   eig_seq_ctrl_if seq_if ();

   eig_seq_ctrl #(.TIMEOUT_CYC(TO_CYC)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .seq_if (seq_if)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      seq_if.calc_start     = 1'b0;
      seq_if.core_busy      = 1'b0;
      seq_if.core_kappa     = $urandom;
      seq_if.core_inv_kappa = $urandom;
      seq_if.core_regime    = 3'($urandom);
      seq_if.ol_busy        = 1'b0;
   endtask

   task automatic check_all(input string p, input int c, input logic rv, input logic os,
                            input logic busy);
      check_eq($sformatf("%s res_valid c%0d", p, c), 32'(seq_if.res_valid), 32'(rv));
      check_eq($sformatf("%s ol_start c%0d", p, c), 32'(seq_if.ol_start), 32'(os));
      check_eq($sformatf("%s seq_busy c%0d", p, c), 32'(seq_if.seq_busy), 32'(busy));
      check_eq($sformatf("%s word_a c%0d", p, c), seq_if.ol_word_a, m_word_a);
      check_eq($sformatf("%s word_b c%0d", p, c), seq_if.ol_word_b, m_word_b);
      check_eq($sformatf("%s mode c%0d", p, c), 32'(seq_if.ol_mode), 32'(m_mode));
      check_eq($sformatf("%s err_overrun c%0d", p, c), 32'(seq_if.err_overrun), 32'(m_ovr));
      check_eq($sformatf("%s err_timeout c%0d", p, c), 32'(seq_if.err_timeout), 32'(m_tmo));
   endtask

   task automatic model_reset();
      m_word_a = '0;
      m_word_b = '0;
      m_mode   = '0;
      m_ovr    = 1'b0;
      m_tmo    = 1'b0;
   endtask

   task automatic apply_reset();
      drive_idle();
      rst = 1'b1;
      step();
      step();
      model_reset();
      check_all("reset", 0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   // One transaction: core busy n cycles, loader backpressure b cycles in LAUNCH,
   // loader busy l cycles after ol_start, optional extra calc_start at cycle ov (0 = none).
   // Timing: res_valid @ n+2, ol_start @ n+3+b, back in IDLE @ n+5+b+l.
   task automatic run_txn(input string p, input logic [31:0] ka, input logic [31:0] ik,
                          input logic [2:0] rg, input int n, input int b, input int l,
                          input int ov);
      int e;
      int c;
      e = n + 5 + b + l;
      for (int t = 0; t <= e + 2; t++) begin
         seq_if.calc_start = (t == 0) || (ov > 0 && t == ov);
         seq_if.core_busy  = (t >= 1 && t <= n);
         if (t == n + 1) begin
            seq_if.core_kappa     = ka;
            seq_if.core_inv_kappa = ik;
            seq_if.core_regime    = rg;
         end else begin
            seq_if.core_kappa     = $urandom;
            seq_if.core_inv_kappa = $urandom;
            seq_if.core_regime    = 3'($urandom);
         end
         seq_if.ol_busy = (t >= n + 2 && t < n + 2 + b) ||
                          (t >= n + 4 + b && t < n + 4 + b + l);
         if (ov > 0 && t == ov) m_ovr = 1'b1;
         step();
         c = t + 1;
         if (c == n + 2) begin
            m_word_a = ka;
            m_word_b = ik;
            m_mode   = rg;
         end
         check_all(p, c, (c == n + 2), (c == n + 3 + b), (c < e));
      end
      drive_idle();
   endtask

   initial begin
      int n, b, l, ov, e;
      rst = 1'b1;
      model_reset();
      drive_idle();
      apply_reset();

      run_txn("nominal", 32'h0001_8000, 32'hFFFF_4000, 3'd2, 5, 0, 2, 0);
      run_txn("backpr", 32'h8000_0001, 32'h7FFF_FFFF, 3'd7, 5, 13, 3, 0);
      run_txn("overrun", 32'hDEAD_BEEF, 32'h0123_4567, 3'd5, 5, 0, 2, 3);

      for (int i = 0; i < 40; i++) begin
         n  = int'($urandom_range(6, 1));
         b  = int'($urandom_range(6, 0));
         l  = int'($urandom_range(5, 1));
         e  = n + 5 + b + l;
         ov = ($urandom_range(1, 0) == 1) ? int'($urandom_range(e - 1, 1)) : 0;
         run_txn($sformatf("rnd%0d", i), $urandom, $urandom, 3'($urandom), n, b, l, ov);
      end

      // Overrun on the exact cycle that returns to IDLE is still dropped
      run_txn("ovr_edge", 32'h0000_0042, 32'hFFFF_FFBE, 3'd1, 2, 1, 2, 2 + 5 + 1 + 2 - 1);

      // rst and calc_start together: reset wins
      seq_if.calc_start = 1'b1;
      rst = 1'b1;
      step();
      model_reset();
      rst = 1'b0;
      seq_if.calc_start = 1'b0;
      check_all("rst_and_start", 1, 1'b0, 1'b0, 1'b0);
      step();
      check_all("rst_and_start", 2, 1'b0, 1'b0, 1'b0);

      // Prime non-zero captured values, then reset in the middle of RUN
      run_txn("pre_rst", 32'hCAFE_F00D, 32'hBADD_CAFE, 3'd6, 3, 0, 1, 0);
      for (int t = 0; t <= 15; t++) begin
         seq_if.calc_start = (t == 0);
         seq_if.core_busy  = (t >= 1 && t <= 10);
         seq_if.ol_busy    = 1'b0;
         rst = (t == 4);
         step();
         if (t == 4) model_reset();
         if (t + 1 >= 5) begin
            check_all("rst_mid_run", t + 1, 1'b0, 1'b0, 1'b0);
         end else begin
            check_eq($sformatf("rst_mid_run seq_busy c%0d", t + 1),
                     32'(seq_if.seq_busy), 32'(t + 1 >= 1));
         end
      end
      rst = 1'b0;
      drive_idle();

`ifdef EIG_SEQ_TIMEOUT_EN
      // core_busy never rises: ABORT at cycle 9, IDLE at 10
      run_txn("pre_tmo", 32'h1111_2222, 32'h3333_4444, 3'd3, 2, 0, 1, 0);
      for (int t = 0; t <= 12; t++) begin
         seq_if.calc_start = (t == 0);
         seq_if.core_busy  = 1'b0;
         step();
         if (t + 1 == int'(TO_CYC) + 1) m_tmo = 1'b1;
         check_all("timeout", t + 1, 1'b0, 1'b0, (t + 1 <= int'(TO_CYC) + 1));
      end
      drive_idle();
      run_txn("post_tmo", 32'h5555_6666, 32'h7777_8888, 3'd4, 3, 2, 2, 0);
`else
      // Without the timeout the sequencer waits in ARM indefinitely
      for (int t = 0; t < 2000; t++) begin
         seq_if.calc_start = (t == 0);
         seq_if.core_busy  = 1'b0;
         step();
         if ((t % 250) == 249 || t == 1999) begin
            check_all("no_tmo", t + 1, 1'b0, 1'b0, 1'b1);
         end
      end
      drive_idle();
      apply_reset();
      run_txn("post_wait", 32'h5555_6666, 32'h7777_8888, 3'd4, 3, 2, 2, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
